// File: rtl/mul32_arb_if.sv
// Request, multiplier and response signals of the two-requester shared-multiplier arbiter.
// slave is the arbiter's view; master is the requester/multiplier side.
interface mul32_arb_if;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_mode;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_mode;
  logic        req1_ready;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_mode;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_mode,
    input  req1_valid, req1_a, req1_b, req1_mode,
    input  mul_hi, mul_lo,
    output req0_ready, req1_ready,
    output mul_a, mul_b, mul_mode,
    output rsp0_valid, rsp1_valid, rsp_hi, rsp_lo
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_mode,
    output req1_valid, req1_a, req1_b, req1_mode,
    output mul_hi, mul_lo,
    input  req0_ready, req1_ready,
    input  mul_a, mul_b, mul_mode,
    input  rsp0_valid, rsp1_valid, rsp_hi, rsp_lo
  );
endinterface

// File: rtl/mul32_arb.sv
// Round-robin arbiter sharing one LAT-cycle pipelined 32x32 multiplier between two requesters.
// Optional per-requester accept counters are enabled with macro MUL32_ARB_STATS_EN.
module mul32_arb #(
  parameter int unsigned LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  mul32_arb_if.slave  bus
`ifdef MUL32_ARB_STATS_EN
  ,
  output logic [31:0] cnt0,
  output logic [31:0] cnt1
`endif
);

  logic           r_ptr;
  logic [LAT-1:0] r_tag_vld;
  logic [LAT-1:0] r_tag_id;
  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_gnt;

  // r_ptr = 1 gives requester 1 priority when both are valid.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      w_gnt0 = bus.req0_valid && (!bus.req1_valid || !r_ptr);
      w_gnt1 = bus.req1_valid && (!bus.req0_valid || r_ptr);
    end
    w_gnt = w_gnt0 || w_gnt1;
  end

  always_comb begin
    bus.req0_ready = w_gnt0;
    bus.req1_ready = w_gnt1;
    bus.mul_a      = '0;
    bus.mul_b      = '0;
    bus.mul_mode   = 1'b0;
    if (w_gnt0) begin
      bus.mul_a    = bus.req0_a;
      bus.mul_b    = bus.req0_b;
      bus.mul_mode = bus.req0_mode;
    end else if (w_gnt1) begin
      bus.mul_a    = bus.req1_a;
      bus.mul_b    = bus.req1_b;
      bus.mul_mode = bus.req1_mode;
    end
  end

  always_comb begin
    bus.rsp0_valid = !rst && r_tag_vld[LAT-1] && !r_tag_id[LAT-1];
    bus.rsp1_valid = !rst && r_tag_vld[LAT-1] && r_tag_id[LAT-1];
    bus.rsp_hi     = bus.mul_hi;
    bus.rsp_lo     = bus.mul_lo;
  end

  // Tag pipeline mirrors the multiplier latency and never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= 1'b0;
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld[0] <= w_gnt;
      r_tag_id[0]  <= w_gnt1;
      for (int i = 1; i < LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
      if (w_gnt) begin
        r_ptr <= w_gnt0;
      end
    end
  end

`ifdef MUL32_ARB_STATS_EN
  logic [31:0] r_cnt0;
  logic [31:0] r_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_gnt0) r_cnt0 <= r_cnt0 + 32'd1;
      if (w_gnt1) r_cnt1 <= r_cnt1 + 32'd1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule
